// File: rtl/reg_file_rename_if.sv
// Bus between the rename register file and its neighbours (ROB commit/tail,
// decoder queries, ROB value lookup). The reg file is the slave side.
interface reg_file_rename_if #(parameter int ROB_WIDTH_BIT = 4);
    logic                     rdy_in;
    logic                     clear_in;
    logic [4:0]               cm_reg_id;
    logic [31:0]              cm_val;
    logic [ROB_WIDTH_BIT-1:0] cm_rob_id;
    logic [4:0]               ren_reg_id;
    logic [ROB_WIDTH_BIT-1:0] ren_rob_id;
    logic [4:0]               q_rs1;
    logic [4:0]               q_rs2;
    logic [ROB_WIDTH_BIT-1:0] rob_rs1_id;
    logic                     rob_rs1_ready;
    logic [31:0]              rob_rs1_val;
    logic [ROB_WIDTH_BIT-1:0] rob_rs2_id;
    logic                     rob_rs2_ready;
    logic [31:0]              rob_rs2_val;
    logic                     rs1_dep;
    logic [ROB_WIDTH_BIT-1:0] rs1_tag;
    logic [31:0]              rs1_val;
    logic                     rs2_dep;
    logic [ROB_WIDTH_BIT-1:0] rs2_tag;
    logic [31:0]              rs2_val;

    // No valid/ready pairs: rdy_in is a global enable, every query is answered
    // combinationally in the same cycle and every update lands on the next edge.
    modport master (
        output rdy_in, clear_in, cm_reg_id, cm_val, cm_rob_id, ren_reg_id, ren_rob_id,
        output q_rs1, q_rs2, rob_rs1_ready, rob_rs1_val, rob_rs2_ready, rob_rs2_val,
        input  rob_rs1_id, rob_rs2_id, rs1_dep, rs1_tag, rs1_val, rs2_dep, rs2_tag, rs2_val
    );

    modport slave (
        input  rdy_in, clear_in, cm_reg_id, cm_val, cm_rob_id, ren_reg_id, ren_rob_id,
        input  q_rs1, q_rs2, rob_rs1_ready, rob_rs1_val, rob_rs2_ready, rob_rs2_val,
        output rob_rs1_id, rob_rs2_id, rs1_dep, rs1_tag, rs1_val, rs2_dep, rs2_tag, rs2_val
    );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags; answers
// operand queries with commit-bypass and ROB forwarding.
module reg_file_rename #(
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    reg_file_rename_if.slave    bus
);
    logic [31:0]              val_q [32];
    logic [31:0]              val_d [32];
    logic [31:0]              busy_q;
    logic [31:0]              busy_d;
    logic [ROB_WIDTH_BIT-1:0] tag_q [32];
    logic [ROB_WIDTH_BIT-1:0] tag_d [32];

    // Commit first, then rename/clear on top so a same-cycle rename keeps the
    // register busy. x0 is never written because both ids are checked non-zero.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (bus.cm_reg_id != 5'd0) begin
            val_d[bus.cm_reg_id] = bus.cm_val;
            if (busy_q[bus.cm_reg_id] && tag_q[bus.cm_reg_id] == bus.cm_rob_id)
                busy_d[bus.cm_reg_id] = 1'b0;
        end
        if (bus.clear_in) begin
            busy_d = '0;
        end else if (bus.ren_reg_id != 5'd0) begin
            busy_d[bus.ren_reg_id] = 1'b1;
            tag_d[bus.ren_reg_id]  = bus.ren_rob_id;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (bus.rdy_in) begin
            busy_q <= busy_d;
            val_q  <= val_d;
            tag_q  <= tag_d;
        end
    end

    // Queries read the registered state only, so a rename in this cycle is invisible.
    always_comb begin
        bus.rob_rs1_id = '0;
        bus.rs1_dep    = 1'b0;
        bus.rs1_tag    = '0;
        bus.rs1_val    = '0;
        if (bus.q_rs1 != 5'd0) begin
            bus.rob_rs1_id = tag_q[bus.q_rs1];
            if (busy_q[bus.q_rs1])
                bus.rs1_tag = tag_q[bus.q_rs1];
            if (!busy_q[bus.q_rs1])
                bus.rs1_val = val_q[bus.q_rs1];
            else if (bus.cm_reg_id == bus.q_rs1 && bus.cm_rob_id == tag_q[bus.q_rs1])
                bus.rs1_val = bus.cm_val;
            else if (bus.rob_rs1_ready)
                bus.rs1_val = bus.rob_rs1_val;
            else
                bus.rs1_dep = 1'b1;
        end
    end

    always_comb begin
        bus.rob_rs2_id = '0;
        bus.rs2_dep    = 1'b0;
        bus.rs2_tag    = '0;
        bus.rs2_val    = '0;
        if (bus.q_rs2 != 5'd0) begin
            bus.rob_rs2_id = tag_q[bus.q_rs2];
            if (busy_q[bus.q_rs2])
                bus.rs2_tag = tag_q[bus.q_rs2];
            if (!busy_q[bus.q_rs2])
                bus.rs2_val = val_q[bus.q_rs2];
            else if (bus.cm_reg_id == bus.q_rs2 && bus.cm_rob_id == tag_q[bus.q_rs2])
                bus.rs2_val = bus.cm_val;
            else if (bus.rob_rs2_ready)
                bus.rs2_val = bus.rob_rs2_val;
            else
                bus.rs2_dep = 1'b1;
        end
    end
endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file (x0..x31) with per-register rename tags for the out-of-order core.
- Sits downstream of the reorder buffer's commit port: it consumes committed writes and new-tail allocations.
- Sits upstream of dispatch: it answers decoder operand queries, forwarding ROB-held values when the producer has finished but not committed.
- Flushes all rename state on a misprediction clear.

Parameters:
ROB_WIDTH_BIT, 4, width of a ROB entry index (ROB holds 2^ROB_WIDTH_BIT entries)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  ready; all state holds when low
clear_in  input  1  misprediction flush from ROB
cm_reg_id  input  5  committed destination register; 0 = no commit
cm_val  input  32  committed value
cm_rob_id  input  ROB_WIDTH_BIT  ROB index of committing entry
ren_reg_id  input  5  register being renamed by dispatch; 0 = none
ren_rob_id  input  ROB_WIDTH_BIT  ROB tail index assigned to ren_reg_id
q_rs1  input  5  decoder source-1 register
q_rs2  input  5  decoder source-2 register
rob_rs1_id  output  ROB_WIDTH_BIT  tag sent to ROB for source-1 lookup
rob_rs1_ready  input  1  ROB reports entry rob_rs1_id has a value
rob_rs1_val  input  32  that value
rob_rs2_id  output  ROB_WIDTH_BIT  tag sent to ROB for source-2 lookup
rob_rs2_ready  input  1  ROB reports entry rob_rs2_id has a value
rob_rs2_val  input  32  that value
rs1_dep  output  1  source-1 still waits on a ROB entry
rs1_tag  output  ROB_WIDTH_BIT  ROB entry source-1 waits on
rs1_val  output  32  source-1 value (valid when rs1_dep=0)
rs2_dep  output  1  source-2 still waits on a ROB entry
rs2_tag  output  ROB_WIDTH_BIT  ROB entry source-2 waits on
rs2_val  output  32  source-2 value (valid when rs2_dep=0)

Behaviour:
- State per register: val[31:0], busy bit, tag[ROB_WIDTH_BIT-1:0]. x0 is hardwired: val 0, never busy; writes and renames to x0 are ignored.
- Reset (rst_in=1 at posedge): all val=0, busy=0, tag=0. rst_in takes priority over everything.
- Update priority at posedge, only when rdy_in=1:
  - Commit (cm_reg_id≠0): val[cm_reg_id] <= cm_val always. busy[cm_reg_id] <= 0 only if busy and tag==cm_rob_id, i.e. no younger rename is pending.
  - Rename (ren_reg_id≠0, clear_in=0): busy[ren_reg_id] <= 1, tag <= ren_rob_id.
  - Rename and commit to the same register in the same cycle: rename wins; the register stays busy with the new tag, and the value write still occurs.
  - clear_in=1: all busy <= 0. Any rename in that cycle is dropped. A commit value write in the same cycle is still performed.
- rdy_in=0: no state change. Combinational outputs keep tracking their inputs.
- Query (purely combinational, per source, rs1 shown):
  - q_rs1=0 → dep=0, val=0.
  - !busy[q] → dep=0, val=val[q].
  - busy[q] and cm_reg_id==q and cm_rob_id==tag[q] (same-cycle commit bypass) → dep=0, val=cm_val.
  - busy[q] and rob_rs1_ready=1 → dep=0, val=rob_rs1_val.
  - Otherwise → dep=1, tag=tag[q], val=0.
- rob_rs1_id is always tag[q_rs1], or 0 when q_rs1=0.
- rs1_tag = tag[q_rs1] whenever busy, else 0.
- Queries see pre-rename state: a rename in the same cycle does not affect the current answer (source read before rd renamed).
- No handshake stalls; zero-latency lookup, one-cycle latency for state update.

Test Plan:
- Reset, then query q_rs1=5, q_rs2=0 → rs1_dep=0, rs1_val=0, rs2_val=0, rob_rs1_id=0.
- ren x3→tag 2; next cycle query x3 with rob_rs1_ready=0 → rs1_dep=1, rs1_tag=2, rob_rs1_id=2. With rob_rs1_ready=1, rob_rs1_val=0x55 → rs1_dep=0, rs1_val=0x55.
- x3 busy tag 2; commit cm_reg_id=3, cm_rob_id=2, cm_val=0xAB while querying x3 → same-cycle rs1_val=0xAB, dep=0. Next cycle busy clear, val=0xAB.
- x3 renamed tag 2 then tag 4; commit (3, rob 2, 0x11) → val[3]=0x11 but still busy tag 4. Simultaneous commit (3, rob 4) + rename (3, tag 6) → busy, tag 6.
- Rename x7, x8, then clear_in=1 with rename x9 the same cycle → next cycle x7, x8, x9 all dep=0. Committed values are retained.
- rdy_in=0 with rename x4 and commit x5 asserted → no state change. Rename/commit to x0 → x0 always reads 0, dep=0.
